// File: rtl/seq_pattern_tx_pkg.sv
// rtl/seq_pattern_tx_pkg.sv - shared state type and length-width helper for the serial pattern transmitter
package seq_tx_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} seq_tx_state_t;

  // Width needed to hold the value w itself; never narrower than one bit.
  function automatic int len_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - strobe/request/serial bus of seq_pattern_tx (repeat_req under SEQ_TX_REPEAT_EN)
interface seq_pattern_tx_if #(parameter int width = 8) ();
  import seq_tx_pkg::*;

  localparam int lw = len_width(width);

  logic          en;
  logic          start;
  logic [width-1:0] pattern;
  logic [lw-1:0] len;
  logic          seq_out;
  logic          busy;
  logic          done;
`ifdef SEQ_TX_REPEAT_EN
  logic          repeat_req;

  modport master (output en, start, pattern, len, repeat_req, input seq_out, busy, done);
  modport slave  (input en, start, pattern, len, repeat_req, output seq_out, busy, done);
`else
  modport master (output en, start, pattern, len, input seq_out, busy, done);
  modport slave  (input en, start, pattern, len, output seq_out, busy, done);
`endif

endinterface

// File: rtl/seq_pattern_tx_down_counter.sv
// rtl/seq_pattern_tx_down_counter.sv - loadable down-counter with decrement enable and zero flag
module seq_tx_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern sender with zero gap; SEQ_TX_REPEAT_EN adds auto-repeat
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int width   = 8,
  parameter int gap_len = 2
) (
  input  logic clk,
  input  logic reset_n,
  seq_pattern_tx_if.slave bus
);

  localparam int lw = len_width(width);
  localparam int gw = len_width(gap_len);

  seq_tx_state_t    state, state_d;
  logic [width-1:0] shadow_pattern;
  logic             seq_out_q, busy_q, done_q;
  logic             seq_out_d, busy_d, done_d;
  logic             bit_load, bit_dec, bit_zero;
  logic [lw-1:0]    bit_load_val, bit_count;
  logic             gap_load, gap_dec, gap_zero;
  logic [gw-1:0]    gap_count;
  logic             accept, complete, rerun;

`ifdef SEQ_TX_REPEAT_EN
  logic [lw-1:0]    shadow_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shadow_len <= '0;
    else if (accept) shadow_len <= bus.len;
  end

  assign rerun = complete && bus.repeat_req;
`else
  assign rerun = 1'b0;
`endif

  assign accept   = (state == IDLE) && bus.start && (bus.len != '0) && (bus.len <= lw'(width));
  // gap_zero also ends the gap so a stray zero count can never stall the block.
  assign complete = bus.en &&
                    (((state == SEND) && bit_zero && (gap_len == 0)) ||
                     ((state == GAP) && ((gap_count == gw'(1)) || gap_zero)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (bus.en && bit_zero && (gap_len > 0)) state_d = GAP;
      GAP:     ;
      default: state_d = IDLE;
    endcase
    if (complete) state_d = rerun ? SEND : IDLE;
  end

  always_comb begin
    seq_out_d    = seq_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    bit_load     = 1'b0;
    bit_load_val = bus.len - 1'b1;
    bit_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        bit_load  = 1'b1;
        seq_out_d = bus.pattern[bit_load_val];
        busy_d    = 1'b1;
      end
      SEND: if (bus.en) begin
        if (!bit_zero) begin
          bit_dec   = 1'b1;
          seq_out_d = shadow_pattern[bit_count - 1'b1];
        end else if (gap_len > 0) begin
          seq_out_d = 1'b0;
          gap_load  = 1'b1;
        end
      end
      GAP:     if (bus.en) gap_dec = 1'b1;
      default: ;
    endcase
    if (complete) begin
      done_d    = 1'b1;
      seq_out_d = 1'b0;
      busy_d    = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
      if (bus.repeat_req) begin
        busy_d       = 1'b1;
        bit_load     = 1'b1;
        bit_load_val = shadow_len - 1'b1;
        seq_out_d    = shadow_pattern[bit_load_val];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_out_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      shadow_pattern <= '0;
    end else begin
      seq_out_q <= seq_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (accept) shadow_pattern <= bus.pattern;
    end
  end

  seq_tx_down_counter #(.W(lw)) u_bit_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (bit_load),
    .load_val (bit_load_val),
    .dec      (bit_dec),
    .count    (bit_count),
    .zero     (bit_zero)
  );

  seq_tx_down_counter #(.W(gw)) u_gap_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (gw'(gap_len)),
    .dec      (gap_dec),
    .count    (gap_count),
    .zero     (gap_zero)
  );

  assign bus.seq_out = seq_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx (repeat case under SEQ_TX_REPEAT_EN)
module tb_seq_pattern_tx;
  import seq_tx_pkg::*;

  localparam int width = 8;
  localparam int lw    = len_width(width);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [2:0]       start_v;
  logic [width-1:0] pattern;
  logic [lw-1:0]    len;
`ifdef SEQ_TX_REPEAT_EN
  logic             repeat_req;
`endif

  int   tests = 0;
  int   fails = 0;
  int   done_cnt [3];
  int   bit_idx = 0;
  logic q [$];

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.width(width)) if_a ();
  seq_pattern_tx_if #(.width(width)) if_b ();
  seq_pattern_tx_if #(.width(width)) if_c ();

  assign if_a.en = en;  assign if_a.start = start_v[0];
  assign if_b.en = en;  assign if_b.start = start_v[1];
  assign if_c.en = en;  assign if_c.start = start_v[2];
  assign if_a.pattern = pattern;  assign if_a.len = len;
  assign if_b.pattern = pattern;  assign if_b.len = len;
  assign if_c.pattern = pattern;  assign if_c.len = len;
`ifdef SEQ_TX_REPEAT_EN
  assign if_a.repeat_req = 1'b0;
  assign if_b.repeat_req = 1'b0;
  assign if_c.repeat_req = repeat_req;
`endif

  seq_pattern_tx #(.width(width), .gap_len(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  seq_pattern_tx #(.width(width), .gap_len(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  seq_pattern_tx #(.width(width), .gap_len(1)) dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  initial begin
    done_cnt[0] = 0; done_cnt[1] = 0; done_cnt[2] = 0;
  end

  always @(posedge clk) begin
    if (if_a.done === 1'b1) done_cnt[0]++;
    if (if_b.done === 1'b1) done_cnt[1]++;
    if (if_c.done === 1'b1) done_cnt[2]++;
  end

  function automatic logic get_seq(int d);
    case (d)
      0:       return if_a.seq_out;
      1:       return if_b.seq_out;
      default: return if_c.seq_out;
    endcase
  endfunction

  function automatic logic get_busy(int d);
    case (d)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  function automatic logic get_done(int d);
    case (d)
      0:       return if_a.done;
      1:       return if_b.done;
      default: return if_c.done;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial stream: len bits MSB-first from bit len-1, then g zeros.
  task automatic push_pattern(input logic [7:0] p, input int l, input int g);
    for (int i = l - 1; i >= 0; i--) q.push_back(p[i]);
    for (int i = 0; i < g; i++) q.push_back(1'b0);
  endtask

  task automatic request(input int d, input logic [7:0] p, input logic [lw-1:0] l);
    @(negedge clk);
    pattern    = p;
    len        = l;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v    = '0;
  endtask

  // One en strobe every 4 cycles; done/busy sampled the cycle after the strobe edge.
  task automatic strobe(input int d, output logic dn, output logic bs);
    @(negedge clk);
    en = 1'b1;
    if (q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
    else chk($sformatf("bit%0d", bit_idx), get_seq(d), q.pop_front());
    bit_idx++;
    @(negedge clk);
    en = 1'b0;
    dn = get_done(d);
    bs = get_busy(d);
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_strobes(input int d, input int n, input string name);
    logic dn, bs;
    for (int i = 0; i < n; i++) begin
      strobe(d, dn, bs);
      chk({name, "_done"}, dn, (i == n - 1) ? 32'd1 : 32'd0);
      if (i == n - 1) chk({name, "_busy_end"}, bs, 32'd0);
    end
  endtask

  task automatic run(input int d, input logic [7:0] p, input logic [lw-1:0] l, input int g,
                     input string name);
    int n0;
    n0 = done_cnt[d];
    push_pattern(p, int'(l), g);
    request(d, p, l);
    chk({name, "_accept"}, get_busy(d), 32'd1);
    finish_strobes(d, int'(l) + g, name);
    chk({name, "_done_pulses"}, done_cnt[d] - n0, 32'd1);
  endtask

  initial begin
    int   n0;
    logic dn, bs;
    en = 1'b0; start_v = '0; pattern = '0; len = '0; reset_n = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
    repeat_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_seq_out", if_a.seq_out, 32'd0);
    chk("reset_busy", if_a.busy, 32'd0);
    chk("reset_done", if_a.done, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset mid-transfer must clear outputs at once, before any clock edge.
    push_pattern(8'h06, 4, 2);
    request(0, 8'h06, 4);
    chk("midrst_accept", if_a.busy, 32'd1);
    strobe(0, dn, bs);
    strobe(0, dn, bs);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_seq_out", if_a.seq_out, 32'd0);
    chk("midrst_busy", if_a.busy, 32'd0);
    chk("midrst_done", if_a.done, 32'd0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle_busy", if_a.busy, 32'd0);

    run(0, 8'h06, 4, 2, "basic");
    run(0, 8'hA5, 8, 2, "full");
    run(1, 8'h01, 1, 0, "single");

    request(0, 8'h06, 0);
    chk("len0_ignored", if_a.busy, 32'd0);
    request(0, 8'h06, 9);
    chk("len_over_ignored", if_a.busy, 32'd0);

    // A second start while busy must not disturb the stream in flight.
    n0 = done_cnt[0];
    push_pattern(8'h06, 4, 2);
    request(0, 8'h06, 4);
    chk("busy_start_accept", if_a.busy, 32'd1);
    strobe(0, dn, bs);
    request(0, 8'hFF, 8);
    finish_strobes(0, 5, "busy_start");
    chk("busy_start_done_pulses", done_cnt[0] - n0, 32'd1);

    n0 = done_cnt[0];
    push_pattern(8'h05, 3, 2);
    @(negedge clk);
    pattern = 8'h05; len = 3; start_v[0] = 1'b1; en = 1'b1;
    @(negedge clk);
    start_v = '0; en = 1'b0;
    chk("simul_accept", if_a.busy, 32'd1);
    finish_strobes(0, 5, "simul");
    chk("simul_done_pulses", done_cnt[0] - n0, 32'd1);

`ifdef SEQ_TX_REPEAT_EN
    n0 = done_cnt[2];
    repeat_req = 1'b1;
    for (int k = 0; k < 3; k++) push_pattern(8'h0B, 4, 1);
    request(2, 8'h0B, 4);
    chk("repeat_accept", if_c.busy, 32'd1);
    for (int i = 0; i < 10; i++) begin
      strobe(2, dn, bs);
      chk("repeat_done", dn, (i % 5 == 4) ? 32'd1 : 32'd0);
      chk("repeat_busy", bs, 32'd1);
    end
    repeat_req = 1'b0;
    finish_strobes(2, 5, "repeat_last");
    chk("repeat_done_pulses", done_cnt[2] - n0, 32'd3);
`endif

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
